// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES-128 types, controller states, constants and byte-level round helpers.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} ctrl_state_t;

  localparam int unsigned AES128_NR = 10;
  localparam aes_byte_t   RCON_INIT = 8'h01;
  localparam aes_byte_t   RCON_POLY = 8'h1b;

  // Forward S-box; element 0 sits in the most significant byte.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic aes_byte_t xtime(input aes_byte_t r);
    return {r[6:0], 1'b0} ^ (r[7] ? RCON_POLY : 8'h00);
  endfunction

  function automatic aes_byte_t sbox(input aes_byte_t b);
    return SBOX[b];
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i of the block is row i%4, column i/4; row r rotates left by r columns.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    return o;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t o;
    aes_byte_t  a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-level handshake bus of the AES round sequencer.
interface aes_round_sequencer_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_block_t plaintext;
  aes_block_t key_in;
  logic       out_valid;
  logic       out_ready;
  aes_block_t ciphertext;
  logic       busy;
  logic [3:0] round_num;

  modport master (
    output in_valid, plaintext, key_in, out_ready,
    input  in_ready, out_valid, ciphertext, busy, round_num
  );

  modport slave (
    input  in_valid, plaintext, key_in, out_ready,
    output in_ready, out_valid, ciphertext, busy, round_num
  );
endinterface

// File: rtl/aes_round_sequencer_key_step.sv
// Single AES-128 key-expansion step: next round key from (key, rcon).
module aes_key_step
  import aes_pkg::*;
(
  input  aes_block_t key,
  input  aes_byte_t  rcon,
  output aes_block_t key_next
);

  logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

  // RotWord + SubWord + Rcon on the last word, then the XOR chain across words.
  always_comb begin
    w0   = key[127:96];
    w1   = key[95:64];
    w2   = key[63:32];
    w3   = key[31:0];
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon, 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    key_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: one round per clock.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES128_NR
) (
  input logic                  clk,
  input logic                  n_rst,
  aes_round_sequencer_if.slave bus
);

  if (NR != AES128_NR) begin : g_bad_nr
    $error("aes_round_sequencer: only NR=10 (AES-128) is supported");
  end

  ctrl_state_t state, state_n;
  aes_block_t  state_reg, key_reg, ct_reg, key_next, round_out, sr_out, mc_out;
  aes_byte_t   rcon;
  logic [3:0]  round_num;
  logic        accept, deliver, last_round;

  aes_key_step u_key_step (
    .key      (key_reg),
    .rcon     (rcon),
    .key_next (key_next)
  );

  assign last_round = (round_num == 4'(NR));

  // Round datapath; the final round skips MixColumns.
  always_comb begin
    sr_out    = shift_rows(sub_bytes(state_reg));
    mc_out    = last_round ? sr_out : mix_columns(sr_out);
    round_out = mc_out ^ key_next;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    deliver = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_n = ROUND;
        end
      end
      ROUND: begin
        if (last_round) state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          deliver = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  // Block, key, Rcon, round counter and ciphertext holding registers.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      ct_reg    <= '0;
      rcon      <= RCON_INIT;
      round_num <= '0;
    end else if (accept) begin
      state_reg <= bus.plaintext ^ bus.key_in;
      key_reg   <= bus.key_in;
      rcon      <= RCON_INIT;
      round_num <= 4'd1;
    end else if (state == ROUND) begin
      state_reg <= round_out;
      key_reg   <= key_next;
      rcon      <= xtime(rcon);
      round_num <= round_num + 4'd1;
      if (last_round) ct_reg <= round_out;
    end else if (deliver) begin
      round_num <= '0;
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);
  assign bus.ciphertext = ct_reg;
  assign bus.round_num  = round_num;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed + randomized bench for aes_round_sequencer with a byte-level AES model.
module tb_aes_round_sequencer;

  localparam int PERIOD = 10;

  logic clk = 1'b0;
  logic n_rst;
  always #(PERIOD/2) clk = ~clk;

  aes_round_sequencer_if bus();

  aes_round_sequencer #(.NR(10)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [127:0] va, vak, vc, vck, vd, vdk;
  logic [127:0] bp [3];
  logic [127:0] bk [3];
  logic [7:0]   rc;
  int           lat, n;
  longint       t_prev;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   r;
    logic [127:0] o;
    r = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {r, 24'h0};
        r   = gmul(r, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row + 4*c] = s[row + 4*((c + row) % 4)];
      for (int c = 0; c < 4; c++) begin
        if (rnd != 10) begin
          s[4*c]   = gmul(t[4*c],8'd2) ^ gmul(t[4*c+1],8'd3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'd2) ^ gmul(t[4*c+2],8'd3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'd2) ^ gmul(t[4*c+3],8'd3);
          s[4*c+3] = gmul(t[4*c],8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'd2);
        end else begin
          for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one transaction in IDLE; returns #1 after the accepting edge.
  task automatic start(input logic [127:0] pt, input logic [127:0] key);
    bus.plaintext = pt;
    bus.key_in    = key;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
  endtask

  // Counts edges from the accepting edge until out_valid is visible to the consumer.
  task automatic wait_out(output int l);
    l = 1;
    while (bus.out_valid !== 1'b1 && l < 40) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key_in    = '0;
    n_rst         = 1'b0;
    build_sbox();
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;

    // Reset state
    check("rst_in_ready",  bus.in_ready,   1);
    check("rst_out_valid", bus.out_valid,  0);
    check("rst_busy",      bus.busy,       0);
    check("rst_round_num", bus.round_num,  0);
    check("rst_ct",        bus.ciphertext, 0);
    check("rst_rcon",      dut.rcon,       8'h01);

    // FIPS-197 C.1 with out_ready tied high
    bus.out_ready = 1'b1;
    start(C1_PT, C1_KEY);
    wait_out(lat);
    check("c1_latency", lat, 11);
    check("c1_ct", bus.ciphertext, C1_CT);
    @(posedge clk); #1;
    check("c1_idle_in_ready", bus.in_ready,   1);
    check("c1_idle_out_valid", bus.out_valid, 0);
    check("c1_idle_round_num", bus.round_num, 0);
    check("c1_ct_held", bus.ciphertext, C1_CT);

    // FIPS-197 B: round counter and Rcon progression, then backpressure
    bus.out_ready = 1'b0;
    start(B_PT, B_KEY);
    rc = 8'h01;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("b_round_num_%0d", k), bus.round_num, k);
      check($sformatf("b_rcon_%0d", k), dut.rcon, rc);
      check($sformatf("b_busy_%0d", k), bus.busy, 1);
      rc = gmul(rc, 8'h02);
      @(posedge clk); #1;
    end
    check("b_out_valid", bus.out_valid, 1);
    check("b_ct", bus.ciphertext, B_CT);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_ct", bus.ciphertext, B_CT);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_release_out_valid", bus.out_valid, 0);
    check("bp_release_busy", bus.busy, 0);

    // in_valid activity during ROUND and DONE must be ignored
    va = rnd128(); vak = rnd128(); vc = rnd128(); vck = rnd128();
    bus.out_ready = 1'b0;
    start(va, vak);
    for (int k = 0; k < 6; k++) begin
      bus.in_valid  = (k % 2 == 0);
      bus.plaintext = rnd128();
      bus.key_in    = rnd128();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("ign_ct", bus.ciphertext, ref_encrypt(va, vak));
    bus.plaintext = vc;
    bus.key_in    = vck;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("ign_done_out_valid", bus.out_valid, 1);
      check("ign_done_ct", bus.ciphertext, ref_encrypt(va, vak));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("ign_handshake_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("second_accepted_busy", bus.busy, 1);
    wait_out(lat);
    check("second_latency", lat, 11);
    check("second_ct", bus.ciphertext, ref_encrypt(vc, vck));
    @(posedge clk); #1;

    // Reset at round 5 discards the block
    vd = rnd128(); vdk = rnd128();
    start(vd, vdk);
    n = 0;
    while (bus.round_num !== 4'd5 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_reached_round5", bus.round_num, 5);
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_round_num", bus.round_num, 0);
    check("midrst_ct", bus.ciphertext, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    start(C1_PT, C1_KEY);
    wait_out(lat);
    check("postrst_latency", lat, 11);
    check("postrst_ct", bus.ciphertext, C1_CT);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      bp[i] = rnd128();
      bk[i] = rnd128();
    end
    bus.plaintext = bp[0];
    bus.key_in    = bk[0];
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.plaintext = bp[1];
    bus.key_in    = bk[1];
    wait_out(lat);
    check("b2b_latency_0", lat, 11);
    check("b2b_ct_0", bus.ciphertext, ref_encrypt(bp[0], bk[0]));
    t_prev = longint'($time);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk);
      @(posedge clk); #1;
      if (i == 1) begin
        bus.plaintext = bp[2];
        bus.key_in    = bk[2];
      end else begin
        bus.in_valid = 1'b0;
      end
      wait_out(lat);
      check($sformatf("b2b_latency_%0d", i), lat, 11);
      check($sformatf("b2b_spacing_%0d", i), (longint'($time) - t_prev) / PERIOD, 12);
      check($sformatf("b2b_ct_%0d", i), bus.ciphertext, ref_encrypt(bp[i], bk[i]));
      t_prev = longint'($time);
    end
    @(posedge clk); #1;

    // Randomized single transactions
    for (int i = 0; i < 4; i++) begin
      va  = rnd128();
      vak = rnd128();
      start(va, vak);
      wait_out(lat);
      check($sformatf("rand_latency_%0d", i), lat, 11);
      check($sformatf("rand_ct_%0d", i), bus.ciphertext, ref_encrypt(va, vak));
      @(posedge clk); #1;
      check($sformatf("rand_idle_%0d", i), bus.in_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
